// File: rtl/io_buffer_if.sv
// Store-side bus from the LSU into the memory-mapped I/O register bank.
interface io_buffer_if;
  logic        st_en;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_bmask;

  modport master (output st_en, output st_addr, output st_data, output st_bmask);
  modport slave  (input  st_en, input  st_addr, input  st_data, input  st_bmask);
endinterface

// File: rtl/io_buffer.sv
// Memory-mapped I/O store buffers plus synchronised switch/button input buffers.
// Optional per-bit input debounce is enabled by defining IO_DEBOUNCE_EN.
module io_buffer #(
  parameter int unsigned SW_W      = 18,
  parameter int unsigned BTN_W     = 4,
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  io_buffer_if.slave          st_bus,
  input  logic [SW_W-1:0]     i_io_sw,
  input  logic [BTN_W-1:0]    i_io_btn,
  output logic [31:0]         o_b_io_ledr,
  output logic [31:0]         o_b_io_ledg,
  output logic [31:0]         o_b_io_hexl,
  output logic [31:0]         o_b_io_hexh,
  output logic [31:0]         o_b_io_lcd,
  output logic [31:0]         o_b_io_sw,
  output logic [31:0]         o_b_io_btn,
  output logic [BTN_W-1:0]    o_btn_press
);

  localparam logic [19:0] PAGE_LEDR = 20'h10000;
  localparam logic [19:0] PAGE_LEDG = 20'h10001;
  localparam logic [19:0] PAGE_HEXL = 20'h10002;
  localparam logic [19:0] PAGE_HEXH = 20'h10003;
  localparam logic [19:0] PAGE_LCD  = 20'h10004;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_LEDR = 3'd1,
    SEL_LEDG = 3'd2,
    SEL_HEXL = 3'd3,
    SEL_HEXH = 3'd4,
    SEL_LCD  = 3'd5
  } sel_e;

  if (SW_W == 0 || SW_W > 32) begin : g_bad_sw_w
    $error("io_buffer: SW_W must be within 1..32");
  end
  if (BTN_W == 0 || BTN_W > 32) begin : g_bad_btn_w
    $error("io_buffer: BTN_W must be within 1..32");
  end
  if (DB_CYCLES == 16'd0) begin : g_bad_db_cycles
    $error("io_buffer: DB_CYCLES must be at least 1");
  end

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  sel_e              sel_s;
  logic [31:0]       ledr_q, ledr_d, ledg_q, ledg_d, hexl_q, hexl_d;
  logic [31:0]       hexh_q, hexh_d, lcd_q, lcd_d;
  logic [SW_W-1:0]   sw_sync1_q, sw_sync2_q, sw_s, sw_q, sw_d;
  logic [BTN_W-1:0]  btn_sync1_q, btn_sync2_q, btn_s, btn_q, btn_d;
  logic [BTN_W-1:0]  press_q, press_d;
  logic              unused_addr_s;

  assign unused_addr_s = ^st_bus.st_addr[11:0];

  always_comb begin
    case (st_bus.st_addr[31:12])
      PAGE_LEDR: sel_s = SEL_LEDR;
      PAGE_LEDG: sel_s = SEL_LEDG;
      PAGE_HEXL: sel_s = SEL_HEXL;
      PAGE_HEXH: sel_s = SEL_HEXH;
      PAGE_LCD:  sel_s = SEL_LCD;
      default:   sel_s = SEL_NONE;  // includes the read-only SW/BTN pages
    endcase
  end

  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    hexl_d = hexl_q;
    hexh_d = hexh_q;
    lcd_d  = lcd_q;
    if (st_bus.st_en) begin
      case (sel_s)
        SEL_LEDR: ledr_d = merge_lanes(ledr_q, st_bus.st_data, st_bus.st_bmask);
        SEL_LEDG: ledg_d = merge_lanes(ledg_q, st_bus.st_data, st_bus.st_bmask);
        SEL_HEXL: hexl_d = merge_lanes(hexl_q, st_bus.st_data, st_bus.st_bmask);
        SEL_HEXH: hexh_d = merge_lanes(hexh_q, st_bus.st_data, st_bus.st_bmask);
        SEL_LCD:  lcd_d  = merge_lanes(lcd_q,  st_bus.st_data, st_bus.st_bmask);
        default:  ledr_d = ledr_q;
      endcase
    end else begin
      ledr_d = ledr_q;
    end
  end

  // Buttons are active-low on the pins; invert after the synchroniser so pressed = 1.
  assign sw_s  = sw_sync2_q;
  assign btn_s = ~btn_sync2_q;

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DB_CYCLES > 16'd1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 16'd1);

  logic [SW_W-1:0][CNT_W-1:0]  sw_cnt_q, sw_cnt_d;
  logic [BTN_W-1:0][CNT_W-1:0] btn_cnt_q, btn_cnt_d;

  always_comb begin
    sw_d     = sw_q;
    sw_cnt_d = sw_cnt_q;
    for (int k = 0; k < SW_W; k++) begin
      if (sw_s[k] == sw_q[k]) begin
        sw_cnt_d[k] = '0;
      end else if (sw_cnt_q[k] == CNT_LAST) begin
        sw_d[k]     = sw_s[k];
        sw_cnt_d[k] = '0;
      end else begin
        sw_cnt_d[k] = sw_cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    btn_d     = btn_q;
    btn_cnt_d = btn_cnt_q;
    for (int k = 0; k < BTN_W; k++) begin
      if (btn_s[k] == btn_q[k]) begin
        btn_cnt_d[k] = '0;
      end else if (btn_cnt_q[k] == CNT_LAST) begin
        btn_d[k]     = btn_s[k];
        btn_cnt_d[k] = '0;
      end else begin
        btn_cnt_d[k] = btn_cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sw_cnt_q  <= '0;
      btn_cnt_q <= '0;
    end else begin
      sw_cnt_q  <= sw_cnt_d;
      btn_cnt_q <= btn_cnt_d;
    end
  end
`else
  always_comb begin
    sw_d  = sw_s;
    btn_d = btn_s;
  end
`endif

  // Press pulse coincides with the first cycle the buffer bit reads 1.
  assign press_d = btn_d & ~btn_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ledr_q      <= 32'h0000_0000;
      ledg_q      <= 32'h0000_0000;
      hexl_q      <= 32'h0000_0000;
      hexh_q      <= 32'h0000_0000;
      lcd_q       <= 32'h0000_0000;
      sw_sync1_q  <= '0;
      sw_sync2_q  <= '0;
      btn_sync1_q <= '1;
      btn_sync2_q <= '1;
      sw_q        <= '0;
      btn_q       <= '0;
      press_q     <= '0;
    end else begin
      ledr_q      <= ledr_d;
      ledg_q      <= ledg_d;
      hexl_q      <= hexl_d;
      hexh_q      <= hexh_d;
      lcd_q       <= lcd_d;
      sw_sync1_q  <= i_io_sw;
      sw_sync2_q  <= sw_sync1_q;
      btn_sync1_q <= i_io_btn;
      btn_sync2_q <= btn_sync1_q;
      sw_q        <= sw_d;
      btn_q       <= btn_d;
      press_q     <= press_d;
    end
  end

  assign o_b_io_ledr = ledr_q;
  assign o_b_io_ledg = ledg_q;
  assign o_b_io_hexl = hexl_q;
  assign o_b_io_hexh = hexh_q;
  assign o_b_io_lcd  = lcd_q;
  assign o_b_io_sw   = 32'(sw_q);
  assign o_b_io_btn  = 32'(btn_q);
  assign o_btn_press = press_q;

endmodule

// File: tb/tb_io_buffer.sv
// Scoreboard bench for io_buffer: directed stimulus queues expected values, a negedge monitor checks them.
module tb_io_buffer;

`ifdef IO_DEBOUNCE_EN
  localparam logic [15:0] TB_DB = 16'd8;
`else
  localparam logic [15:0] TB_DB = 16'd50000;
`endif

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] sw;
  logic [3:0]  btn;
  logic [31:0] ledr, ledg, hexl, hexh, lcd, bsw, bbtn;
  logic [3:0]  press;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        exp_q[$];
  logic [31:0] m_buf [5];
  string       names [8] = '{"ledr", "ledg", "hexl", "hexh", "lcd", "sw", "btn", "press"};

  io_buffer_if bus();

  io_buffer #(.SW_W(18), .BTN_W(4), .DB_CYCLES(TB_DB)) dut (
    .i_clk(clk), .i_reset(rst_n), .st_bus(bus),
    .i_io_sw(sw), .i_io_btn(btn),
    .o_b_io_ledr(ledr), .o_b_io_ledg(ledg), .o_b_io_hexl(hexl),
    .o_b_io_hexh(hexh), .o_b_io_lcd(lcd), .o_b_io_sw(bsw),
    .o_b_io_btn(bbtn), .o_btn_press(press)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0: return ledr;
      1: return ledg;
      2: return hexl;
      3: return hexh;
      4: return lcd;
      5: return bsw;
      6: return bbtn;
      7: return {28'h0, press};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
      if (exp_q[i].due <= cyc) begin
        total++;
        if (exp_q[i].due < cyc) begin
          bad++;
          $display("FAIL %s missed check due=%0d now=%0d", names[exp_q[i].sel], exp_q[i].due, cyc);
        end else if (actual(exp_q[i].sel) !== exp_q[i].val) begin
          bad++;
          $display("FAIL %s cyc=%0d got=%h exp=%h", names[exp_q[i].sel], cyc,
                   actual(exp_q[i].sel), exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic push(input int due, input int sel, input logic [31:0] val);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_all_zero(input int due);
    for (int s = 0; s < 8; s++) push(due, s, 32'h0);
  endtask

  // idx = -1 means the store must not change any buffer.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input int idx, input logic [31:0] expv);
    tick();
    bus.st_en    = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_bmask = m;
    if (idx >= 0) m_buf[idx] = expv;
    for (int s = 0; s < 5; s++) push(cyc + 1, s, m_buf[s]);
  endtask

  task automatic idle_bus();
    tick();
    bus.st_en    = 1'b0;
    bus.st_bmask = 4'h0;
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    sw = 18'h0;
    btn = 4'hF;
    bus.st_en = 1'b0;
    bus.st_addr = 32'h0;
    bus.st_data = 32'h0;
    bus.st_bmask = 4'h0;
    for (int s = 0; s < 5; s++) m_buf[s] = 32'h0;

    repeat (3) tick();
    push_all_zero(cyc);
    tick();
    rst_n = 1'b1;
    for (int d = 1; d <= 10; d++) push_all_zero(cyc + d);
    repeat (11) tick();

    store(32'h1000_0000, 32'hDEAD_BEEF, 4'hF,    0, 32'hDEAD_BEEF);
    store(32'h1000_0004, 32'h0000_1200, 4'b0010, 0, 32'hDEAD_12EF);
    store(32'h1000_2000, 32'h0000_003F, 4'hF,    2, 32'h0000_003F);
    store(32'h1000_3000, 32'h0606_0606, 4'hF,    3, 32'h0606_0606);
    store(32'h1000_4000, 32'h8000_0041, 4'hF,    4, 32'h8000_0041);
    store(32'h1001_0000, 32'hFFFF_FFFF, 4'hF,   -1, 32'h0);
    store(32'h1001_1000, 32'hFFFF_FFFF, 4'hF,   -1, 32'h0);
    store(32'h2000_0000, 32'hFFFF_FFFF, 4'hF,   -1, 32'h0);
    store(32'h1000_1ABC, 32'h1234_5678, 4'b1001, 1, 32'h1200_0078);
    store(32'h1000_1000, 32'hFFFF_FFFF, 4'h0,    1, 32'h1200_0078);
    store(32'h1000_0FFC, 32'h0000_0000, 4'b1000, 0, 32'h00AD_12EF);
    idle_bus();
    for (int s = 0; s < 5; s++) push(cyc + 2, s, m_buf[s]);
    repeat (3) tick();

`ifndef IO_DEBOUNCE_EN
    sw = 18'h2A5A5;
    push(cyc + 2, 5, 32'h0000_0000);
    push(cyc + 3, 5, 32'h0002_A5A5);
    repeat (4) tick();
    sw = 18'h3FFFF;
    push(cyc + 2, 5, 32'h0002_A5A5);
    push(cyc + 3, 5, 32'h0003_FFFF);
    repeat (4) tick();

    btn = 4'b1011;
    c = cyc;
    for (int d = 0; d <= 10; d++) begin
      push(c + d, 6, (d >= 3 && d <= 7) ? 32'h4 : 32'h0);
      push(c + d, 7, (d == 3) ? 32'h4 : 32'h0);
    end
    repeat (5) tick();
    btn = 4'hF;
    repeat (7) tick();

    btn = 4'b0110;
    c = cyc;
    for (int d = 0; d <= 5; d++) begin
      push(c + d, 6, (d >= 3) ? 32'h9 : 32'h0);
      push(c + d, 7, (d == 3) ? 32'h9 : 32'h0);
    end
    repeat (6) tick();
    btn = 4'hF;
    repeat (5) tick();
`else
    btn = 4'b1110;
    c = cyc;
    for (int d = 0; d <= 12; d++) begin
      push(c + d, 6, 32'h0);
      push(c + d, 7, 32'h0);
    end
    repeat (5) tick();
    btn = 4'hF;
    repeat (8) tick();

    btn = 4'b1110;
    c = cyc;
    for (int d = 0; d <= 24; d++) begin
      push(c + d, 6, (d >= 10) ? 32'h1 : 32'h0);
      push(c + d, 7, (d == 10) ? 32'h1 : 32'h0);
    end
    repeat (20) tick();
    btn = 4'hF;
    repeat (15) tick();

    btn = 4'b1110;
    repeat (6) tick();
    rst_n = 1'b0;
    push_all_zero(cyc);
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    btn = 4'hF;
    c = cyc;
    for (int d = 0; d <= 15; d++) push(c + d, 6, 32'h0);
    repeat (16) tick();
`endif

    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
